// File: rtl/mux_4to1_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin output channel:
// requester count, select width, FSM state encoding and a one-hot helper.
package mux_4to1_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] res;
        res      = '0;
        res[idx] = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/mux_4to1.sv
// Plain 4:1 word multiplexer; steers the granted requester onto the output register input.
module mux_4to1 #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    input  logic [1:0]   sel,
    output logic [N-1:0] out
);

    always_comb begin
        out = a;
        unique case (sel)
            2'd0: out = a;
            2'd1: out = b;
            2'd2: out = c;
            2'd3: out = d;
            default: out = a;
        endcase
    end

endmodule

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output stage between
// four req/ack requesters; the ack is registered together with the captured word.
module mux_4to1_rr_arbiter
    import mux_4to1_rr_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   in_req,
    input  logic [NUM_REQ*N-1:0] in_data,
    input  logic [NUM_REQ-1:0]   in_mask,
    output logic [NUM_REQ-1:0]   in_ack,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic [SEL_W-1:0]     out_sel
);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt;
    logic [SEL_W-1:0]   grant;
    logic               found;
    logic               load;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] ack_nxt;
    logic [N-1:0]       mux_out;
    logic [N-1:0]       data_nxt;
    logic [SEL_W-1:0]   sel_nxt;

    // Returns {found, index}: the first set bit of elig scanning ptr, ptr+1, ... mod 4.
    // Scanning from the farthest offset down lets the nearest hit overwrite the result.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                               input logic [SEL_W-1:0]   start);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = start + SEL_W'(k);
            if (req_v[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign elig           = in_req & in_mask;
    assign {found, grant} = rr_pick(elig, ptr);
    assign out_valid      = (state == ST_FULL);

    mux_4to1 #(
        .N(N)
    ) u_mux (
        .a  (in_data[0*N +: N]),
        .b  (in_data[1*N +: N]),
        .c  (in_data[2*N +: N]),
        .d  (in_data[3*N +: N]),
        .sel(grant),
        .out(mux_out)
    );

    always_comb begin
        load      = (state == ST_EMPTY) | (out_valid & out_ready);
        state_nxt = state;
        ptr_nxt   = ptr;
        ack_nxt   = '0;
        data_nxt  = out_data;
        sel_nxt   = out_sel;
        if (load) begin
            if (found) begin
                state_nxt = ST_FULL;
                ptr_nxt   = grant + SEL_W'(1);
                ack_nxt   = onehot(grant);
                data_nxt  = mux_out;
                sel_nxt   = grant;
            end else begin
                // Nothing to take: the slot drains, word/select keep their last value.
                state_nxt = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            ptr      <= '0;
            in_ack   <= '0;
            out_data <= '0;
            out_sel  <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            in_ack   <= ack_nxt;
            out_data <= data_nxt;
            out_sel  <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Table-driven bench for mux_4to1_rr_arbiter with a queue scoreboard of expected outputs.
module tb_mux_4to1_rr_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  mask;
        logic [15:0] data;
        logic        ready;
        logic        exp_valid;
        logic [3:0]  exp_data;
        logic [1:0]  exp_sel;
        logic [3:0]  exp_ack;
    } vec_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] data;
        logic [1:0] sel;
        logic [3:0] ack;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_req;
    logic [15:0] in_data;
    logic [3:0]  in_mask;
    logic [3:0]  in_ack;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_sel;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    vec_t tbl[24];

    mux_4to1_rr_arbiter #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_req   (in_req),
        .in_data  (in_data),
        .in_mask  (in_mask),
        .in_ack   (in_ack),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sel  (out_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic [3:0] req, logic [3:0] mask, logic [15:0] data,
                                logic ready, logic ev, logic [3:0] ed, logic [1:0] es,
                                logic [3:0] ea);
        vec_t v;
        v.req = req; v.mask = mask; v.data = data; v.ready = ready;
        v.exp_valid = ev; v.exp_data = ed; v.exp_sel = es; v.exp_ack = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got none expected one entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".valid"}, 32'(out_valid), 32'(e.valid));
            chk({tag, ".data"},  32'(out_data),  32'(e.data));
            chk({tag, ".sel"},   32'(out_sel),   32'(e.sel));
            chk({tag, ".ack"},   32'(in_ack),    32'(e.ack));
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        in_req    = v.req;
        in_mask   = v.mask;
        in_data   = v.data;
        out_ready = v.ready;
        e.valid = v.exp_valid; e.data = v.exp_data; e.sel = v.exp_sel; e.ack = v.exp_ack;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic expect_zero(input string tag);
        exp_t e;
        e = '0;
        sb.push_back(e);
        check_out(tag);
    endtask

    initial begin
        // Requester data: req3=C, req2=A, req1=5, req0=3
        tbl[0]  = mk(4'hF, 4'hF, 16'hCA53, 1'b1, 1'b1, 4'h3, 2'd0, 4'h1);
        tbl[1]  = mk(4'hF, 4'hF, 16'hCA53, 1'b1, 1'b1, 4'h5, 2'd1, 4'h2);
        tbl[2]  = mk(4'hF, 4'hF, 16'hCA53, 1'b1, 1'b1, 4'hA, 2'd2, 4'h4);
        tbl[3]  = mk(4'hF, 4'hF, 16'hCA53, 1'b1, 1'b1, 4'hC, 2'd3, 4'h8);
        tbl[4]  = mk(4'hF, 4'hF, 16'hCA53, 1'b1, 1'b1, 4'h3, 2'd0, 4'h1);
        tbl[5]  = mk(4'hF, 4'hF, 16'hCA53, 1'b1, 1'b1, 4'h5, 2'd1, 4'h2);
        tbl[6]  = mk(4'h5, 4'hF, 16'h1234, 1'b0, 1'b1, 4'h5, 2'd1, 4'h0);
        tbl[7]  = mk(4'hA, 4'h5, 16'hFFFF, 1'b0, 1'b1, 4'h5, 2'd1, 4'h0);
        tbl[8]  = mk(4'h0, 4'hF, 16'h0000, 1'b0, 1'b1, 4'h5, 2'd1, 4'h0);
        tbl[9]  = mk(4'hF, 4'hF, 16'hCA53, 1'b1, 1'b1, 4'hA, 2'd2, 4'h4);
        tbl[10] = mk(4'hF, 4'hA, 16'hCA53, 1'b1, 1'b1, 4'hC, 2'd3, 4'h8);
        tbl[11] = mk(4'hF, 4'hA, 16'hCA53, 1'b1, 1'b1, 4'h5, 2'd1, 4'h2);
        tbl[12] = mk(4'hF, 4'hA, 16'hCA53, 1'b1, 1'b1, 4'hC, 2'd3, 4'h8);
        tbl[13] = mk(4'hF, 4'hA, 16'hCA53, 1'b1, 1'b1, 4'h5, 2'd1, 4'h2);
        tbl[14] = mk(4'h8, 4'hF, 16'hE000, 1'b1, 1'b1, 4'hE, 2'd3, 4'h8);
        tbl[15] = mk(4'h0, 4'hF, 16'hE000, 1'b1, 1'b0, 4'hE, 2'd3, 4'h0);
        tbl[16] = mk(4'h3, 4'hF, 16'h0021, 1'b1, 1'b1, 4'h1, 2'd0, 4'h1);
        tbl[17] = mk(4'h0, 4'hF, 16'h0021, 1'b1, 1'b0, 4'h1, 2'd0, 4'h0);
        tbl[18] = mk(4'h4, 4'hF, 16'h0900, 1'b1, 1'b1, 4'h9, 2'd2, 4'h4);
        tbl[19] = mk(4'h0, 4'hF, 16'h0900, 1'b1, 1'b0, 4'h9, 2'd2, 4'h0);
        tbl[20] = mk(4'h2, 4'hF, 16'h0070, 1'b1, 1'b1, 4'h7, 2'd1, 4'h2);
        tbl[21] = mk(4'h2, 4'hF, 16'h0070, 1'b1, 1'b1, 4'h7, 2'd1, 4'h2);
        tbl[22] = mk(4'h2, 4'hF, 16'h0070, 1'b1, 1'b1, 4'h7, 2'd1, 4'h2);
        tbl[23] = mk(4'h1, 4'hE, 16'h0070, 1'b1, 1'b0, 4'h7, 2'd1, 4'h0);

        rst       = 1'b1;
        in_req    = '0;
        in_mask   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_zero("reset_init");
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Load a word and stall, then reset between edges: word must vanish at once.
        run_vec(mk(4'hF, 4'hF, 16'hCA53, 1'b0, 1'b1, 4'hA, 2'd2, 4'h4), "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        expect_zero("rst_async");
        @(posedge clk);
        #1;
        expect_zero("rst_held_edge");
        rst = 1'b0;
        run_vec(mk(4'hF, 4'hF, 16'hCA53, 1'b1, 1'b1, 4'h3, 2'd0, 4'h1), "post_rst_grant0");
        run_vec(mk(4'hF, 4'hF, 16'hCA53, 1'b1, 1'b1, 4'h5, 2'd1, 4'h2), "post_rst_grant1");

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d leftover entries expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
